// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned DefClkMhz   = 50;
  localparam int unsigned DefBaud     = 115200;
  localparam int unsigned DefIdleBits = 20;

  // Clocks per bit, truncated.
  function automatic int unsigned bit_cycles(input int unsigned clk_mhz,
                                             input int unsigned baud);
    return (clk_mhz * 32'd1_000_000) / baud;
  endfunction

  localparam int unsigned Cycle     = bit_cycles(DefClkMhz, DefBaud);
  localparam int unsigned IdleTicks = DefIdleBits * Cycle;
  localparam int unsigned CntWidth  = $clog2(Cycle);
  localparam int unsigned IdleWidth = $clog2(IdleTicks + 1);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw UART line plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin,
  output logic line,
  output logic fall
);

  // [0]=sync1, [1]=sync2, [2]=sync3; reset high so release never looks like a start edge.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rx_pin};
    end
  end

  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_frame_rx.sv
// 8N1 UART byte receiver with a one-deep output register and idle-gap frame delimiting.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = DefClkMhz,
  parameter int unsigned BAUD_RATE  = DefBaud,
  parameter int unsigned IDLE_CYCLE = DefIdleBits
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_ack,
  output logic       rx_frame_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned CycleLen = bit_cycles(CLK_FRE, BAUD_RATE);
  localparam int unsigned IdleLen  = IDLE_CYCLE * CycleLen;
  localparam int unsigned CntW     = $clog2(CycleLen);
  localparam int unsigned IdleW    = $clog2(IdleLen + 1);

  localparam logic [CntW-1:0]  SampleAt = CntW'(CycleLen / 2 - 1);
  localparam logic [CntW-1:0]  LastCnt  = CntW'(CycleLen - 1);
  localparam logic [IdleW-1:0] IdleFull = IdleW'(IdleLen);

  logic line, fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .line   (line),
    .fall   (fall)
  );

  uart_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             pending_q, pending_d;
  logic [IdleW-1:0] idle_q, idle_d;

  logic sample, last, load, bad_stop, accept, frame_fire;

  assign sample     = (cnt_q == SampleAt);
  assign last       = (cnt_q == LastCnt);
  assign accept     = valid_q & rx_data_ready;
  assign frame_fire = (idle_q == IdleFull) & pending_q & ~valid_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
    bad_stop  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        cnt_d = cnt_q + CntW'(1);
        if (sample && line) begin
          state_d = StIdle;
        end else if (last) begin
          state_d   = StData;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        cnt_d = cnt_q + CntW'(1);
        if (sample) begin
          shift_d[bit_cnt_q] = line;
        end
        if (last) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        cnt_d = cnt_q + CntW'(1);
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (sample) begin
          state_d  = StIdle;
          load     = line;
          bad_stop = ~line;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    idle_d    = idle_q;
    err_d     = bad_stop;
    ovr_d     = 1'b0;

    // Accept is applied before load, so a same-cycle pair is never an overrun.
    if (accept) begin
      valid_d   = 1'b0;
      pending_d = 1'b1;
    end
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~accept;
    end

    if (frame_fire) begin
      pending_d = 1'b0;
    end

    if (fall || frame_fire) begin
      idle_d = '0;
    end else if (state_q == StIdle && line && idle_q != IdleFull) begin
      idle_d = idle_q + IdleW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      pending_q <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      pending_q <= pending_d;
      idle_q    <= idle_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_ack        = accept;
  assign rx_frame_ack  = frame_fire;
  assign rx_frame_err  = err_q;
  assign rx_overrun    = ovr_q;

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-level UART receiver with idle-gap frame delimiting. Oversamples the asynchronous `rx_pin`, recovers 8N1 bytes and presents each on a ready/valid port. It pulses `rx_ack` per delivered byte and `rx_frame_ack` once the line has stayed idle for a programmable number of bit times after at least one byte. It sits directly upstream of the byte-to-register packer in the UART register-receive path, and its `rx_ack` and `rx_frame_ack` drive the packer's write and frame-reset inputs.

## Interface
- `CLK_FRE`, 50, system clock in MHz
- `BAUD_RATE`, 115200, line rate in bit/s
- `IDLE_CYCLE`, 20, idle gap in bit periods that closes a frame
- `clk`  in  1  single system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rx_pin`  in  1  raw UART line, idle high, asynchronous to `clk`
- `rx_data`  out  8  received byte, LSB first on the line; reset 8'h00
- `rx_data_valid`  out  1  byte held on `rx_data`; reset 0
- `rx_data_ready`  in  1  consumer accepts the byte when high with valid
- `rx_ack`  out  1  one-cycle pulse = `rx_data_valid & rx_data_ready`; reset 0
- `rx_frame_ack`  out  1  one-cycle end-of-frame pulse; reset 0
- `rx_frame_err`  out  1  one-cycle pulse on bad stop bit; reset 0
- `rx_overrun`  out  1  one-cycle pulse when an unconsumed byte is overwritten; reset 0

## Operation
- CYCLE = CLK_FRE*1_000_000/BAUD_RATE, with integer truncation. The default is 434. The sample point is cnt == CYCLE/2-1.
- `rx_pin` passes through a 2-FF synchronizer. A falling edge is detected from sync2 versus sync3.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge moves to START and clears cnt.
  - START: at the sample point, a high line returns to IDLE as a glitch with no output. At cnt == CYCLE-1 the FSM moves to DATA with bit_cnt = 0.
  - DATA: at the sample point, `shift[bit_cnt]` takes the line. At cnt == CYCLE-1, bit_cnt increments. After bit 7 the FSM moves to STOP.
  - STOP: at the sample point the FSM returns to IDLE early, which allows resync for a back-to-back start.
    - A high line loads `rx_data` and sets valid.
    - A low line pulses `rx_frame_err` and discards the byte.
- Output holding register:
  - `rx_data_valid` clears on the `rx_ack` cycle.
  - If a new byte lands while valid is still high, the new byte overwrites `rx_data`, valid stays high and `rx_overrun` pulses.
  - A load and an accept in the same cycle count as an accept followed by a load, with no overrun.
- Frame logic:
  - `pending` sets on `rx_ack`.
  - The idle counter runs only while the FSM is IDLE and sync2 is high. Any falling edge clears it.
  - `rx_frame_ack` pulses when the counter reaches IDLE_CYCLE*CYCLE, `pending` = 1 and `rx_data_valid` = 0. That pulse clears `pending` and the counter.
  - If valid is still held at that point, the frame ack is deferred until the byte is accepted.
  - The counter saturates, so there is no wrap and no repeated frame ack.
- Reset mid-byte: every register returns to its reset value. The FSM goes to IDLE and the partial byte is lost. The synchronizer resets to 1, so no false edge is seen.

## Timing
- Edge detect occurs 2-3 clocks after the `rx_pin` fall.
- `rx_data_valid` rises about 9*CYCLE + CYCLE/2 + 3 clocks after the `rx_pin` fall. The bench tolerance is ±2 clocks.
- `rx_ack` is combinational from valid and ready. With ready tied high, valid is high for exactly 1 cycle.
- `rx_frame_ack` comes IDLE_CYCLE*CYCLE (±2) clocks after the last byte's mid-stop sample, or 1 cycle after the deferred accept. It is never in the same cycle as `rx_ack`.
- Counter widths are $clog2 of CYCLE and of IDLE_CYCLE*CYCLE+1.

## Structure
- Shared package `uart_pkg`: FSM state encodings and localparams for CYCLE, IDLE_TICKS and counter widths. The TX side reuses them.
- Sub-module `uart_rx_sync`: 2-FF synchronizer plus falling-edge detect, reset to 1. Everything else is in this module.

## Test plan
- Single byte: 0xA5 at 115200 baud, ready = 1 → `rx_data` = 0xA5, one `rx_ack`, then one `rx_frame_ack` 8680±2 clocks after the mid-stop sample.
- Back-to-back frame: 0x01, 0x02, 0x03 with no gaps → three `rx_ack` in order, exactly one `rx_frame_ack` after the last byte, no `rx_frame_err`.
- Glitch: `rx_pin` low for 100 clocks → no valid, no error, FSM back in IDLE, no frame ack.
- Framing error: 0x3C with stop bit low → `rx_frame_err` pulse, valid stays 0, `pending` unchanged.
- Backpressure: ready = 0 while 0x11 then 0x22 arrive → `rx_overrun` pulse, `rx_data` = 0x22. Raise ready 20000 clocks later → `rx_ack`, then `rx_frame_ack` 1 clock later.
- Reset mid-byte: assert `rst_n` low during DATA bit 4 → all outputs 0. After release, 0x5A is received cleanly.
